// File: rtl/mem_stage_pkg.sv
// Shared definitions for the MEM stage: instruction-type codes and helpers.
package mem_stage_pkg;

    localparam int INST_TYPE_W = 4;

    localparam logic [INST_TYPE_W-1:0] INST_NOP = 4'd0;
    localparam logic [INST_TYPE_W-1:0] INST_ALU = 4'd1;
    localparam logic [INST_TYPE_W-1:0] INST_LB  = 4'd2;
    localparam logic [INST_TYPE_W-1:0] INST_LH  = 4'd3;
    localparam logic [INST_TYPE_W-1:0] INST_LW  = 4'd4;
    localparam logic [INST_TYPE_W-1:0] INST_LBU = 4'd5;
    localparam logic [INST_TYPE_W-1:0] INST_LHU = 4'd6;
    localparam logic [INST_TYPE_W-1:0] INST_SB  = 4'd7;
    localparam logic [INST_TYPE_W-1:0] INST_SH  = 4'd8;
    localparam logic [INST_TYPE_W-1:0] INST_SW  = 4'd9;

    localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

    // Index of the last byte of an access (access size minus one).
    function automatic logic [1:0] access_last(input logic [INST_TYPE_W-1:0] inst_type);
        case (inst_type)
            INST_LB, INST_LBU, INST_SB: access_last = 2'd0;
            INST_LH, INST_LHU, INST_SH: access_last = 2'd1;
            default:                    access_last = 2'd3;
        endcase
    endfunction

endpackage

// File: rtl/mem_stage_load_ext.sv
// Sign/zero extension of an assembled little-endian load word.
module load_ext
    import mem_stage_pkg::*;
(
    input  logic [31:0]            raw,
    input  logic [INST_TYPE_W-1:0] inst_type,
    output logic [31:0]            result
);

    // Pick the extension by load type; word loads pass through untouched.
    always_comb begin
        result = raw;
        case (inst_type)
            INST_LB:  result = {{24{raw[7]}}, raw[7:0]};
            INST_LH:  result = {{16{raw[15]}}, raw[15:0]};
            INST_LBU: result = {24'h0, raw[7:0]};
            INST_LHU: result = {16'h0, raw[15:0]};
            default:  result = raw;
        endcase
    end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: byte-serial loads/stores over a shared 8-bit RAM port,
// registered write-back, and a stall request while an access is in flight.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int ADDR_W   = 32,
    parameter int READ_LAT = 1
) (
    input  logic                   clk_in,
    input  logic                   rst_in,
    input  logic                   rd_in,
    input  logic [4:0]             rd_addr_in,
    input  logic [31:0]            rd_val_in,
    input  logic [INST_TYPE_W-1:0] inst_type_in,
    input  logic                   load_in,
    input  logic                   store_in,
    input  logic [ADDR_W-1:0]      mem_addr_in,
    input  logic [31:0]            mem_val_in,
    output logic                   mem_req_out,
    input  logic                   mem_gnt_in,
    output logic [ADDR_W-1:0]      mem_a_out,
    output logic                   mem_wr_out,
    output logic [7:0]             mem_dout,
    input  logic [7:0]             mem_din,
    output logic                   wb_en_out,
    output logic [4:0]             wb_addr_out,
    output logic [31:0]            wb_val_out,
    output logic                   stallreq_from_mem
);

    typedef enum logic [1:0] {ST_IDLE, ST_RD, ST_WR, ST_DONE} state_e;

    state_e                 state_reg, state_next;
    logic [2:0]             cnt_reg;
    logic [1:0]             last_reg;
    logic [INST_TYPE_W-1:0] type_reg;
    logic                   rd_en_reg;
    logic [4:0]             rd_addr_reg;
    logic [23:0]            store_data_reg;
    logic [31:0]            load_data_reg;

    logic                   mem_op;
    logic                   busy;
    logic [2:0]             rd_last_cnt;
    logic                   sample;
    logic [1:0]             byte_idx;
    logic [31:0]            load_raw;
    logic [31:0]            load_result;

    assign mem_op      = load_in | store_in;
    // Read state lasts one extra cycle per unit of read latency beyond the last address.
    assign rd_last_cnt = {1'b0, last_reg} + 3'(READ_LAT);
    assign sample      = (state_reg == ST_RD) && (cnt_reg >= 3'(READ_LAT));
    assign byte_idx    = 2'(cnt_reg - 3'(READ_LAT));

    // Merge the byte arriving this cycle into its lane so the final byte is visible at once.
    genvar gi;
    generate
        for (gi = 0; gi < 4; gi++) begin : g_lane
            assign load_raw[8*gi +: 8] = (sample && (byte_idx == 2'(gi))) ? mem_din
                                                                          : load_data_reg[8*gi +: 8];
        end
    endgenerate

    load_ext u_load_ext (
        .raw       (load_raw),
        .inst_type (type_reg),
        .result    (load_result)
    );

    // State register.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) state_reg <= ST_IDLE;
        else         state_reg <= state_next;
    end

    // Next state plus RAM request / stall (both high exactly while an access is pending).
    always_comb begin
        state_next = state_reg;
        busy       = 1'b0;
        case (state_reg)
            ST_IDLE: begin
                busy = mem_op;
                if (mem_op && mem_gnt_in) state_next = load_in ? ST_RD : ST_WR;
            end
            ST_RD: begin
                busy = 1'b1;
                if (cnt_reg == rd_last_cnt) state_next = ST_DONE;
            end
            ST_WR: begin
                busy = 1'b1;
                if (cnt_reg[1:0] == last_reg) state_next = ST_DONE;
            end
            default: state_next = ST_IDLE;
        endcase
        mem_req_out       = busy & rst_in;
        stallreq_from_mem = busy & rst_in;
    end

    // Datapath: operand capture, RAM address/data sequencing and write-back.
    always_ff @(posedge clk_in or negedge rst_in) begin
        if (!rst_in) begin
            cnt_reg        <= '0;
            last_reg       <= '0;
            type_reg       <= INST_NOP;
            rd_en_reg      <= 1'b0;
            rd_addr_reg    <= '0;
            store_data_reg <= '0;
            load_data_reg  <= ZERO_WORD;
            mem_a_out      <= '0;
            mem_wr_out     <= 1'b0;
            mem_dout       <= '0;
            wb_en_out      <= 1'b0;
            wb_addr_out    <= '0;
            wb_val_out     <= ZERO_WORD;
        end else begin
            case (state_reg)
                ST_IDLE: begin
                    if (mem_op) begin
                        wb_en_out <= 1'b0;
                        if (mem_gnt_in) begin
                            type_reg       <= inst_type_in;
                            last_reg       <= access_last(inst_type_in);
                            rd_en_reg      <= rd_in;
                            rd_addr_reg    <= rd_addr_in;
                            store_data_reg <= mem_val_in[31:8];
                            load_data_reg  <= ZERO_WORD;
                            cnt_reg        <= '0;
                            mem_a_out      <= mem_addr_in;
                            mem_wr_out     <= ~load_in;
                            mem_dout       <= mem_val_in[7:0];
                        end
                    end else begin
                        wb_en_out   <= rd_in;
                        wb_addr_out <= rd_addr_in;
                        wb_val_out  <= rd_val_in;
                    end
                end
                ST_RD: begin
                    cnt_reg       <= cnt_reg + 3'd1;
                    load_data_reg <= load_raw;
                    if (cnt_reg < {1'b0, last_reg}) mem_a_out <= mem_a_out + 1'b1;
                    if (cnt_reg == rd_last_cnt) begin
                        wb_en_out   <= rd_en_reg;
                        wb_addr_out <= rd_addr_reg;
                        wb_val_out  <= load_result;
                    end
                end
                ST_WR: begin
                    cnt_reg <= cnt_reg + 3'd1;
                    if (cnt_reg[1:0] == last_reg) begin
                        mem_wr_out <= 1'b0;
                    end else begin
                        mem_a_out      <= mem_a_out + 1'b1;
                        mem_dout       <= store_data_reg[7:0];
                        store_data_reg <= {8'h00, store_data_reg[23:8]};
                    end
                end
                default: begin
                    wb_en_out  <= 1'b0;
                    mem_wr_out <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_mem_stage.sv
// Self-checking bench for mem_stage: vector table plus hand-written timing sequences.
module tb_mem_stage;
    import mem_stage_pkg::*;

    logic                   clk_in = 1'b0;
    logic                   rst_in;
    logic                   rd_in;
    logic [4:0]             rd_addr_in;
    logic [31:0]            rd_val_in;
    logic [INST_TYPE_W-1:0] inst_type_in;
    logic                   load_in;
    logic                   store_in;
    logic [31:0]            mem_addr_in;
    logic [31:0]            mem_val_in;
    logic                   mem_req_out;
    logic                   mem_gnt_in;
    logic [31:0]            mem_a_out;
    logic                   mem_wr_out;
    logic [7:0]             mem_dout;
    logic [7:0]             mem_din = 8'h00;
    logic                   wb_en_out;
    logic [4:0]             wb_addr_out;
    logic [31:0]            wb_val_out;
    logic                   stallreq_from_mem;

    logic                   gnt_allow = 1'b1;
    logic [7:0]             ram [0:4095];
    int                     total = 0;
    int                     passed = 0;

    mem_stage #(.ADDR_W(32), .READ_LAT(1)) dut (
        .clk_in            (clk_in),
        .rst_in            (rst_in),
        .rd_in             (rd_in),
        .rd_addr_in        (rd_addr_in),
        .rd_val_in         (rd_val_in),
        .inst_type_in      (inst_type_in),
        .load_in           (load_in),
        .store_in          (store_in),
        .mem_addr_in       (mem_addr_in),
        .mem_val_in        (mem_val_in),
        .mem_req_out       (mem_req_out),
        .mem_gnt_in        (mem_gnt_in),
        .mem_a_out         (mem_a_out),
        .mem_wr_out        (mem_wr_out),
        .mem_dout          (mem_dout),
        .mem_din           (mem_din),
        .wb_en_out         (wb_en_out),
        .wb_addr_out       (wb_addr_out),
        .wb_val_out        (wb_val_out),
        .stallreq_from_mem (stallreq_from_mem)
    );

    always #5 clk_in = ~clk_in;

    // Arbiter model: grant follows request whenever the bench allows it.
    assign mem_gnt_in = mem_req_out & gnt_allow;

    // 4 KiB byte RAM with one-cycle registered read (address aliased to 12 bits).
    always @(posedge clk_in) begin
        mem_din <= ram[mem_a_out[11:0]];
        if (mem_wr_out) ram[mem_a_out[11:0]] <= mem_dout;
    end

    typedef struct {
        string                  name;
        logic [INST_TYPE_W-1:0] t;
        logic                   ld;
        logic                   st;
        logic [31:0]            addr;
        logic [31:0]            val;
        logic                   rd;
        logic [4:0]             rda;
        logic [31:0]            pre;
        logic [31:0]            exp_val;
        logic                   exp_en;
        int                     exp_stall;
    } vec_t;

    vec_t vecs[$];

    function automatic vec_t mk(string name, logic [INST_TYPE_W-1:0] t, logic ld, logic st,
                                logic [31:0] addr, logic [31:0] val, logic rd, logic [4:0] rda,
                                logic [31:0] pre, logic [31:0] exp_val, logic exp_en, int exp_stall);
        vec_t v;
        v.name = name; v.t = t; v.ld = ld; v.st = st; v.addr = addr; v.val = val;
        v.rd = rd; v.rda = rda; v.pre = pre; v.exp_val = exp_val; v.exp_en = exp_en;
        v.exp_stall = exp_stall;
        return v;
    endfunction

    function automatic int nbytes(logic [INST_TYPE_W-1:0] t);
        if (t == INST_LB || t == INST_LBU || t == INST_SB) return 1;
        if (t == INST_LH || t == INST_LHU || t == INST_SH) return 2;
        return 4;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", name, act, exp);
    endtask

    task automatic bubble();
        rd_in = 1'b0; rd_addr_in = '0; rd_val_in = '0; inst_type_in = INST_NOP;
        load_in = 1'b0; store_in = 1'b0; mem_addr_in = '0; mem_val_in = '0;
    endtask

    task automatic preload(input logic [31:0] addr, input logic [31:0] bytes);
        logic [31:0] a;
        for (int k = 0; k < 4; k++) begin
            a = addr + 32'(k);
            ram[a[11:0]] = bytes[8*k +: 8];
        end
    endtask

    // Apply one instruction as EX would (held while stalled); entered and left at posedge+1.
    task automatic run_vec(input vec_t v);
        logic [31:0] wbv;
        logic [4:0]  wba;
        logic        wben;
        logic [31:0] a;
        logic [7:0]  exp_b;
        int          stalls;
        int          n;
        bit          is_mem;
        is_mem = v.ld | v.st;
        preload(v.addr, v.pre);
        rd_in = v.rd; rd_addr_in = v.rda; rd_val_in = v.val; inst_type_in = v.t;
        load_in = v.ld; store_in = v.st; mem_addr_in = v.addr; mem_val_in = v.val;
        stalls = 0;
        for (n = 0; n < 40; n++) begin
            #2;
            if (!stallreq_from_mem) break;
            stalls++;
            @(posedge clk_in); #1;
        end
        check({v.name, " stall_bound"}, 32'(n < 40), 32'd1);
        wbv = wb_val_out; wba = wb_addr_out; wben = wb_en_out;
        @(posedge clk_in); #1;
        bubble();
        if (!is_mem) begin
            #1;
            wbv = wb_val_out; wba = wb_addr_out; wben = wb_en_out;
        end
        check({v.name, " stalls"}, 32'(stalls), 32'(v.exp_stall));
        check({v.name, " wb_en"}, 32'(wben), 32'(v.exp_en));
        if (v.exp_en || !is_mem) check({v.name, " wb_val"}, wbv, v.exp_val);
        if (v.exp_en) check({v.name, " wb_addr"}, 32'(wba), 32'(v.rda));
        for (int k = 0; k < 4; k++) begin
            a = v.addr + 32'(k);
            exp_b = (v.st && !v.ld && k < nbytes(v.t)) ? v.val[8*k +: 8] : v.pre[8*k +: 8];
            check($sformatf("%s ram[%0d]", v.name, k), 32'(ram[a[11:0]]), 32'(exp_b));
        end
        $display("txn %s: wb_en=%0d wb_addr=%0d wb_val=0x%08h stalls=%0d",
                 v.name, wben, wba, wbv, stalls);
        @(posedge clk_in); #1;
    endtask

    initial begin
        for (int i = 0; i < 4096; i++) ram[i] = 8'h00;
        vecs.push_back(mk("lw_0x100",  INST_LW,  1, 0, 32'h100, 32'hDEADBEEF, 1, 5'd9,  32'h44332211, 32'h44332211, 1, 6));
        vecs.push_back(mk("lb_0x7",    INST_LB,  1, 0, 32'h7,   32'hDEADBEEF, 1, 5'd10, 32'h55AA0080, 32'hFFFFFF80, 1, 3));
        vecs.push_back(mk("lbu_0x7",   INST_LBU, 1, 0, 32'h7,   32'hDEADBEEF, 1, 5'd11, 32'h55AA0080, 32'h00000080, 1, 3));
        vecs.push_back(mk("lhu_0x7",   INST_LHU, 1, 0, 32'h7,   32'hDEADBEEF, 1, 5'd12, 32'h0102FF80, 32'h0000FF80, 1, 4));
        vecs.push_back(mk("lh_neg",    INST_LH,  1, 0, 32'h20,  32'hDEADBEEF, 1, 5'd13, 32'h0000F234, 32'hFFFFF234, 1, 4));
        vecs.push_back(mk("lh_pos",    INST_LH,  1, 0, 32'h22,  32'hDEADBEEF, 1, 5'd14, 32'h99997234, 32'h00007234, 1, 4));
        vecs.push_back(mk("lw_unal",   INST_LW,  1, 0, 32'h33,  32'hDEADBEEF, 1, 5'd15, 32'hEFBEADDE, 32'hEFBEADDE, 1, 6));
        vecs.push_back(mk("lb_x0",     INST_LB,  1, 0, 32'h50,  32'hDEADBEEF, 1, 5'd0,  32'h0000007F, 32'h0000007F, 1, 3));
        vecs.push_back(mk("ld_st_both",INST_LBU, 1, 1, 32'h40,  32'h11111111, 1, 5'd16, 32'h0000005A, 32'h0000005A, 1, 3));
        vecs.push_back(mk("alu_rd3",   INST_ALU, 0, 0, 32'h0,   32'hCAFEBABE, 1, 5'd3,  32'h0,        32'hCAFEBABE, 1, 0));
        vecs.push_back(mk("alu_nord",  INST_ALU, 0, 0, 32'h0,   32'h12345678, 0, 5'd4,  32'h0,        32'h12345678, 0, 0));
        vecs.push_back(mk("sw_0x200",  INST_SW,  0, 1, 32'h200, 32'hA1B2C3D4, 0, 5'd0,  32'hEEEEEEEE, 32'h0,        0, 5));
        vecs.push_back(mk("sb_0x300",  INST_SB,  0, 1, 32'h300, 32'hAABBCC77, 0, 5'd0,  32'hEEEEEEEE, 32'h0,        0, 2));
        vecs.push_back(mk("sh_unal",   INST_SH,  0, 1, 32'h3FF, 32'h0000BEEF, 0, 5'd0,  32'h11223344, 32'h0,        0, 3));

        // Reset state, with a load request present to show stall is held low in reset.
        rst_in = 1'b0;
        bubble();
        load_in = 1'b1; inst_type_in = INST_LW;
        @(posedge clk_in); #2;
        check("rst mem_a_out", mem_a_out, 32'h0);
        check("rst mem_wr_out", 32'(mem_wr_out), 32'h0);
        check("rst mem_dout", 32'(mem_dout), 32'h0);
        check("rst wb_en_out", 32'(wb_en_out), 32'h0);
        check("rst wb_val_out", wb_val_out, 32'h0);
        check("rst wb_addr_out", 32'(wb_addr_out), 32'h0);
        check("rst stall", 32'(stallreq_from_mem), 32'h0);
        check("rst mem_req", 32'(mem_req_out), 32'h0);
        bubble();
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        @(posedge clk_in); #1;

        foreach (vecs[i]) run_vec(vecs[i]);

        // LW @0x100: address sequence and write-back timing.
        preload(32'h100, 32'h44332211);
        rd_in = 1'b1; rd_addr_in = 5'd9; inst_type_in = INST_LW; load_in = 1'b1;
        mem_addr_in = 32'h100; rd_val_in = 32'hDEADBEEF;
        #1;
        check("lwseq A stall", 32'(stallreq_from_mem), 32'h1);
        check("lwseq A req", 32'(mem_req_out), 32'h1);
        for (int k = 0; k < 4; k++) begin
            @(posedge clk_in); #2;
            check($sformatf("lwseq addr%0d", k), mem_a_out, 32'h100 + 32'(k));
            check($sformatf("lwseq wr%0d", k), 32'(mem_wr_out), 32'h0);
            check($sformatf("lwseq stall%0d", k), 32'(stallreq_from_mem), 32'h1);
        end
        @(posedge clk_in); #2;
        check("lwseq A+5 stall", 32'(stallreq_from_mem), 32'h1);
        check("lwseq A+5 wb_en", 32'(wb_en_out), 32'h0);
        @(posedge clk_in); #2;
        check("lwseq A+6 stall", 32'(stallreq_from_mem), 32'h0);
        check("lwseq A+6 req", 32'(mem_req_out), 32'h0);
        check("lwseq A+6 wb_en", 32'(wb_en_out), 32'h1);
        check("lwseq A+6 wb_val", wb_val_out, 32'h44332211);
        @(posedge clk_in); #1;
        bubble();
        #1;
        check("lwseq A+7 wb_en", 32'(wb_en_out), 32'h0);
        check("lwseq A+7 stall", 32'(stallreq_from_mem), 32'h0);
        $display("txn lw_seq: wb_val=0x%08h", 32'h44332211);
        @(posedge clk_in); #1;

        // SH 0x1234ABCD @0x2: byte writes and timing.
        preload(32'h2, 32'h0);
        inst_type_in = INST_SH; store_in = 1'b1; mem_addr_in = 32'h2; mem_val_in = 32'h1234ABCD;
        #1;
        check("shseq A stall", 32'(stallreq_from_mem), 32'h1);
        @(posedge clk_in); #2;
        check("shseq A+1 wr", 32'(mem_wr_out), 32'h1);
        check("shseq A+1 addr", mem_a_out, 32'h2);
        check("shseq A+1 dout", 32'(mem_dout), 32'hCD);
        check("shseq A+1 stall", 32'(stallreq_from_mem), 32'h1);
        @(posedge clk_in); #2;
        check("shseq A+2 wr", 32'(mem_wr_out), 32'h1);
        check("shseq A+2 addr", mem_a_out, 32'h3);
        check("shseq A+2 dout", 32'(mem_dout), 32'hAB);
        @(posedge clk_in); #2;
        check("shseq A+3 stall", 32'(stallreq_from_mem), 32'h0);
        check("shseq A+3 wr", 32'(mem_wr_out), 32'h0);
        check("shseq A+3 wb_en", 32'(wb_en_out), 32'h0);
        @(posedge clk_in); #1;
        bubble();
        #1;
        check("shseq A+4 wb_en", 32'(wb_en_out), 32'h0);
        check("shseq ram2", 32'(ram[2]), 32'hCD);
        check("shseq ram3", 32'(ram[3]), 32'hAB);
        $display("txn sh_seq: ram[2]=0x%02h ram[3]=0x%02h", ram[2], ram[3]);
        @(posedge clk_in); #1;

        // LH @0xFFFFFFFF with grant withheld three cycles; address wraps to 0.
        ram[12'hFFF] = 8'h01; ram[0] = 8'h80;
        gnt_allow = 1'b0;
        rd_in = 1'b1; rd_addr_in = 5'd4; inst_type_in = INST_LH; load_in = 1'b1;
        mem_addr_in = 32'hFFFFFFFF;
        for (int i = 0; i < 3; i++) begin
            #1;
            check($sformatf("wrap nognt%0d stall", i), 32'(stallreq_from_mem), 32'h1);
            check($sformatf("wrap nognt%0d req", i), 32'(mem_req_out), 32'h1);
            check($sformatf("wrap nognt%0d wb_en", i), 32'(wb_en_out), 32'h0);
            @(posedge clk_in); #1;
        end
        gnt_allow = 1'b1;
        #1;
        check("wrap A stall", 32'(stallreq_from_mem), 32'h1);
        @(posedge clk_in); #2;
        check("wrap addr0", mem_a_out, 32'hFFFFFFFF);
        @(posedge clk_in); #2;
        check("wrap addr1", mem_a_out, 32'h00000000);
        @(posedge clk_in); #2;
        check("wrap A+3 stall", 32'(stallreq_from_mem), 32'h1);
        @(posedge clk_in); #2;
        check("wrap A+4 stall", 32'(stallreq_from_mem), 32'h0);
        check("wrap A+4 wb_en", 32'(wb_en_out), 32'h1);
        check("wrap A+4 wb_val", wb_val_out, 32'hFFFF8001);
        $display("txn lh_wrap: wb_val=0x%08h", wb_val_out);
        @(posedge clk_in); #1;
        bubble();
        @(posedge clk_in); #1;

        // Reset asserted in RD after byte 1, then an ALU pass-through after release.
        preload(32'h100, 32'h44332211);
        rd_in = 1'b1; rd_addr_in = 5'd9; inst_type_in = INST_LW; load_in = 1'b1;
        mem_addr_in = 32'h100;
        for (int i = 0; i < 3; i++) @(posedge clk_in);
        @(posedge clk_in); #1;
        rst_in = 1'b0;
        #1;
        check("rstrd mem_a_out", mem_a_out, 32'h0);
        check("rstrd mem_wr_out", 32'(mem_wr_out), 32'h0);
        check("rstrd wb_en_out", 32'(wb_en_out), 32'h0);
        check("rstrd wb_val_out", wb_val_out, 32'h0);
        check("rstrd stall", 32'(stallreq_from_mem), 32'h0);
        check("rstrd req", 32'(mem_req_out), 32'h0);
        @(posedge clk_in); #1;
        rst_in = 1'b1;
        bubble();
        rd_in = 1'b1; rd_addr_in = 5'd7; rd_val_in = 32'h55; inst_type_in = INST_ALU;
        #1;
        check("rstrd addi stall", 32'(stallreq_from_mem), 32'h0);
        @(posedge clk_in); #2;
        check("rstrd addi wb_en", 32'(wb_en_out), 32'h1);
        check("rstrd addi wb_addr", 32'(wb_addr_out), 32'h7);
        check("rstrd addi wb_val", wb_val_out, 32'h55);
        $display("txn reset_mid_load: wb_val=0x%08h", wb_val_out);
        bubble();
        @(posedge clk_in); #1;

        // Back-to-back ALU ops to x5.
        for (int i = 1; i <= 3; i++) begin
            rd_in = 1'b1; rd_addr_in = 5'd5; rd_val_in = 32'(i); inst_type_in = INST_ALU;
            #1;
            check($sformatf("b2b%0d stall", i), 32'(stallreq_from_mem), 32'h0);
            if (i > 1) begin
                check($sformatf("b2b%0d wb_en", i - 1), 32'(wb_en_out), 32'h1);
                check($sformatf("b2b%0d wb_val", i - 1), wb_val_out, 32'(i - 1));
            end
            @(posedge clk_in); #1;
        end
        bubble();
        #1;
        check("b2b3 wb_en", 32'(wb_en_out), 32'h1);
        check("b2b3 wb_addr", 32'(wb_addr_out), 32'h5);
        check("b2b3 wb_val", wb_val_out, 32'h3);
        $display("txn alu_b2b: last wb_val=0x%08h", wb_val_out);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
